// File: rtl/queue.sv
// queue: circular-buffer FIFO with occupancy count, registered read data and read-valid strobe.
// Latency: 1 clock from an accepted Pop to Data_Out/Data_Valid; a push is readable on the next cycle.
// Backpressure: Full/Empty advertise state; pushes while Full (without Pop) and pops while Empty are dropped.
//
// Ports:
//   Clk        - clock, rising edge
//   RstN       - synchronous active-low reset
//   Data_In    - write data, captured on an accepted push
//   Push, Pop  - enqueue / dequeue requests
//   Data_Out   - registered read data, holds when no pop is accepted
//   Data_Valid - one-cycle strobe, Data_Out was loaded on the last edge
//   Count      - current occupancy (0..QUEUE_DEPTH)
//   Full/Empty - decoded from Count
//   Overflow/Underflow - sticky error flags, only live when QUEUE_ERR_FLAGS_EN is defined
//
// Build option: define QUEUE_ERR_FLAGS_EN to synthesize the sticky Overflow/Underflow flags;
// otherwise both outputs are tied low and the ports stay for interface compatibility.
module queue #(
  parameter int QUEUE_DEPTH = 8,
  parameter int QUEUE_WIDTH = 4
) (
  input  logic                             Clk,
  input  logic                             RstN,
  input  logic [QUEUE_WIDTH-1:0]           Data_In,
  input  logic                             Push,
  input  logic                             Pop,
  output logic [QUEUE_WIDTH-1:0]           Data_Out,
  output logic                             Data_Valid,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] Count,
  output logic                             Full,
  output logic                             Empty,
  output logic                             Overflow,
  output logic                             Underflow
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH-1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(QUEUE_DEPTH);

  logic [QUEUE_WIDTH-1:0] mem_q [QUEUE_DEPTH];
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [QUEUE_WIDTH-1:0] dout_q, dout_d;
  logic                   dvld_q, dvld_d;
  logic                   full, empty;
  logic                   do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A push is accepted when there is room, or when a simultaneous pop frees
  // a slot. On an empty queue a paired pop is dropped (no bypass path), so
  // only the push goes through.
  always_comb begin
    do_push = Push && (!full || Pop);
    do_pop  = Pop && !empty;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = dout_q;
    dvld_d  = 1'b0;
    if (do_push) begin
      // Explicit wrap so non-power-of-two depths work.
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
    end
    if (do_pop) begin
      dout_d = mem_q[head_q];
      dvld_d = 1'b1;
      head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      // When full with push+pop, tail == head: the read above takes the old
      // entry (pre-edge value) while this write replaces it.
      if (do_push) begin
        mem_q[tail_q] <= Data_In;
      end
    end
  end

`ifdef QUEUE_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Observes requests only; never feeds back into queue state.
  always_comb begin
    ovf_d = ovf_q | (Push && !Pop && full);
    unf_d = unf_q | (Pop && !Push && empty);
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
`else
  assign Overflow  = 1'b0;
  assign Underflow = 1'b0;
`endif

  assign Data_Out   = dout_q;
  assign Data_Valid = dvld_q;
  assign Count      = count_q;
  assign Full       = full;
  assign Empty      = empty;

endmodule

// File: doc/queue.md
Name: queue

Overview:
- Circular-buffer FIFO queue. It is the first-in-first-out counterpart to the team's LIFO stack: data is written at the tail and read from the opposite end (the head).
- Uses the same Push/Pop/Full/Empty style interface, so either block can be swapped in as a lab datapath buffer.
- Adds an occupancy count, a read-valid strobe and defined simultaneous push/pop behaviour.

Parameters:
- QUEUE_DEPTH, 8, number of entries (>= 2, need not be a power of two).
- QUEUE_WIDTH, 4, bits per entry.

Ports:
- Clk  input  1  clock, all state updates on the rising edge.
- RstN  input  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- Data_In  input  QUEUE_WIDTH  write data, sampled when a push is accepted.
- Push  input  1  enqueue request.
- Pop  input  1  dequeue request.
- Data_Out  output  QUEUE_WIDTH  registered read data.
- Data_Valid  output  1  one-cycle strobe: Data_Out was loaded on the last edge.
- Count  output  $clog2(QUEUE_DEPTH+1)  current occupancy.
- Full  output  1  Count == QUEUE_DEPTH (combinational from Count).
- Empty  output  1  Count == 0 (combinational from Count).
- Overflow  output  1  sticky error flag (see Optional Feature).
- Underflow  output  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (RstN low at a rising edge):
  - head, tail and Count go to 0; Data_Out = 0; Data_Valid = 0; Overflow = Underflow = 0.
  - Storage contents are cleared to 0.
  - Reset overrides any Push/Pop in the same cycle.
  - Reset mid-stream discards all entries; Empty = 1 from the next cycle.
- Storage and pointers:
  - Array of QUEUE_DEPTH x QUEUE_WIDTH.
  - Pointer width: $clog2(QUEUE_DEPTH).
  - Each pointer increments by 1 and wraps from QUEUE_DEPTH-1 to 0 by explicit compare, never by natural overflow.
- Accepted push: mem[tail] <= Data_In; tail advances.
- Accepted pop: Data_Out <= mem[head]; head advances; Data_Valid = 1 for exactly the next cycle.
  - Read latency: 1 clock (data visible after the edge on which Pop was sampled).
- Data_Out holds its last value when no pop is accepted.
- Per-edge decision table (evaluated with pre-edge Count):
  - Push only, not Full: push; Count +1.
  - Push only, Full: ignored; nothing changes.
  - Pop only, not Empty: pop; Count -1.
  - Pop only, Empty: ignored; Data_Out holds; Data_Valid = 0.
  - Push and Pop, Empty: push only; Count +1; no bypass to Data_Out; Data_Valid = 0.
  - Push and Pop, Full: both accepted (oldest read, new written into the freed slot); Count unchanged.
  - Push and Pop, otherwise: both accepted; Count unchanged.
- Count never exceeds QUEUE_DEPTH and never underflows.
- Order is strictly FIFO across any number of pointer wraps.
- No $display or other simulation-only side effects in RTL.

Optional Feature:
- Macro: QUEUE_ERR_FLAGS_EN.
- When defined:
  - Overflow sets when Push && !Pop && Full at an edge.
  - Underflow sets when Pop && !Push && Empty at an edge.
  - Both flags are sticky until reset.
  - Flag logic does not alter queue state.
- When not defined: Overflow and Underflow are tied to 0 and the flag logic is not synthesized. The ports remain, so the interface is identical.

Test Plan:
- Reset then idle 3 cycles -> Empty = 1, Full = 0, Count = 0, Data_Out = 0, Data_Valid = 0.
- Push 1,2,3 then Pop x3 -> Data_Out sequence 1,2,3, each with a Data_Valid pulse one cycle after its Pop; Empty = 1 at end.
- Push 8 values (0..7, defaults) -> Full = 1, Count = 8; 9th push of 0xF ignored (Overflow = 1 if QUEUE_ERR_FLAGS_EN); 8 pops return 0..7.
- Wrap: push 6, pop 6, push 5 values A,B,C,D,E, pop 5 -> returns A..E in order; Count back to 0.
- Simultaneous: with Count = 3 holding 4,5,6, assert Push = 1 (Data_In = 9) and Pop = 1 -> Data_Out = 4, Count = 3; subsequent pops give 5,6,9. Same with queue Full -> Count stays 8, the oldest is returned.
- Push and Pop together on Empty (Data_In = 7) -> Count = 1, Data_Valid = 0, Data_Out unchanged. Pop on empty -> no change (Underflow = 1 if enabled). Then RstN low for one edge while Count = 4 -> Count = 0, flags cleared.
